// File: rtl/wb_ram_arbiter_pkg.sv
// Shared arbiter constants: master indices, FSM state encoding and index helpers.
// Imported by the round-robin picker and the arbiter top.
package wb_ram_arbiter_pkg;

   localparam int         ARB_MASTERS = 3;

   localparam logic [1:0] WB_ARB_CPU  = 2'd0;
   localparam logic [1:0] WB_ARB_DSP  = 2'd1;
   localparam logic [1:0] WB_ARB_DAQ  = 2'd2;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_t;

   // Round-robin successor over the three master indices.
   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      case (idx)
         WB_ARB_CPU: next_idx = WB_ARB_DSP;
         WB_ARB_DSP: next_idx = WB_ARB_DAQ;
         default:    next_idx = WB_ARB_CPU;
      endcase
   endfunction

   function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
      case (oh)
         3'b010:  onehot_to_idx = WB_ARB_DSP;
         3'b100:  onehot_to_idx = WB_ARB_DAQ;
         default: onehot_to_idx = WB_ARB_CPU;
      endcase
   endfunction

endpackage

// File: rtl/wb_ram_arbiter_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping mod 3.
// Zero latency; vld low when nobody requests.
module rr_priority_picker
   import wb_ram_arbiter_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [2:0] gnt,
   output logic       vld
);

   logic [1:0] first;
   logic [1:0] second;
   logic [1:0] third;

   assign first  = next_idx(last);
   assign second = next_idx(first);
   assign third  = next_idx(second);

   always_comb begin
      gnt = 3'b000;
      if (req[first]) begin
         gnt[first] = 1'b1;
      end else if (req[second]) begin
         gnt[second] = 1'b1;
      end else if (req[third]) begin
         gnt[third] = 1'b1;
      end
   end

   assign vld = |req;

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone arbiter granting whole cyc periods of one SRAM slave to 3 masters.
// Grant one edge after cyc; zero-latency response path; stalled owners get err from a watchdog.
module wb_ram_arbiter
   import wb_ram_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 3,
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT     = 255
) (
   input  logic                  wb_clk,
   input  logic                  wb_rst_n,
   input  logic [3*AW-1:0]       m_adr_i,
   input  logic [3*DW-1:0]       m_dat_i,
   input  logic [3*(DW/8)-1:0]   m_sel_i,
   input  logic [2:0]            m_we_i,
   input  logic [2:0]            m_cyc_i,
   input  logic [2:0]            m_stb_i,
   input  logic [8:0]            m_cti_i,
   input  logic [5:0]            m_bte_i,
   output logic [DW-1:0]         m_dat_o,
   output logic [2:0]            m_ack_o,
   output logic [2:0]            m_err_o,
   output logic [2:0]            m_rty_o,
   output logic [AW-1:0]         s_adr_o,
   output logic [DW-1:0]         s_dat_o,
   output logic [DW/8-1:0]       s_sel_o,
   output logic                  s_we_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   output logic [2:0]            s_cti_o,
   output logic [1:0]            s_bte_o,
   input  logic [DW-1:0]         s_dat_i,
   input  logic                  s_ack_i,
   input  logic                  s_err_i,
   input  logic                  s_rty_i,
   output logic [2:0]            grant_o,
   output logic                  timeout_o
);

   localparam int         SW      = DW / 8;
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   if (NUM_MASTERS != ARB_MASTERS) begin : g_bad_masters
      $error("wb_ram_arbiter supports exactly 3 masters");
   end
   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("wb_ram_arbiter TIMEOUT must be within 2..255");
   end

   arb_state_t state;
   logic [2:0] grant;
   logic [1:0] owner;
   logic [1:0] last_owner;
   logic [7:0] wd_cnt;

   logic       owned;
   logic [1:0] sel_idx;
   logic       owner_cyc;
   logic       owner_stb;
   logic       slv_rsp;
   logic       wd_fire;
   logic [2:0] pick_req;
   logic [1:0] pick_last;
   logic [2:0] pick_gnt;
   logic       pick_vld;

   assign owned     = (state == ARB_OWNED);
   assign sel_idx   = owned ? owner : WB_ARB_CPU;
   assign owner_cyc = m_cyc_i[sel_idx];
   assign owner_stb = m_stb_i[sel_idx];
   assign slv_rsp   = s_ack_i | s_err_i | s_rty_i;

   // The watchdog decision depends only on registered count and owner stb,
   // never on the slave response, so a combinational slave cannot form a loop.
   assign wd_fire   = owned & owner_stb & (wd_cnt == WD_LAST);

   assign s_adr_o   = m_adr_i[int'(sel_idx)*AW +: AW];
   assign s_dat_o   = m_dat_i[int'(sel_idx)*DW +: DW];
   assign s_sel_o   = m_sel_i[int'(sel_idx)*SW +: SW];
   assign s_we_o    = m_we_i[sel_idx];
   assign s_cti_o   = m_cti_i[int'(sel_idx)*3 +: 3];
   assign s_bte_o   = m_bte_i[int'(sel_idx)*2 +: 2];
   assign s_cyc_o   = owned & owner_cyc;
   assign s_stb_o   = owned & owner_stb & ~wd_fire;

   assign m_dat_o   = s_dat_i;
   assign m_ack_o   = grant & {3{s_ack_i & ~wd_fire}};
   assign m_rty_o   = grant & {3{s_rty_i & ~wd_fire}};
   assign m_err_o   = grant & {3{s_err_i | wd_fire}};

   assign grant_o   = grant;
   assign timeout_o = wd_fire;

   // In OWNED the picker only matters on the release edge; the releasing
   // master is masked so it cannot win straight back.
   assign pick_req  = owned ? (m_cyc_i & ~grant) : m_cyc_i;
   assign pick_last = owned ? owner : last_owner;

   rr_priority_picker u_picker (
      .req  (pick_req),
      .last (pick_last),
      .gnt  (pick_gnt),
      .vld  (pick_vld)
   );

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state      <= ARB_IDLE;
         grant      <= 3'b000;
         owner      <= WB_ARB_CPU;
         last_owner <= WB_ARB_DAQ;
         wd_cnt     <= 8'd0;
      end else begin
         case (state)
            ARB_IDLE: begin
               wd_cnt <= 8'd0;
               if (pick_vld) begin
                  state <= ARB_OWNED;
                  grant <= pick_gnt;
                  owner <= onehot_to_idx(pick_gnt);
               end
            end
            ARB_OWNED: begin
               if (!owner_cyc) begin
                  last_owner <= owner;
                  wd_cnt     <= 8'd0;
                  if (pick_vld) begin
                     grant <= pick_gnt;
                     owner <= onehot_to_idx(pick_gnt);
                  end else begin
                     state <= ARB_IDLE;
                     grant <= 3'b000;
                     owner <= WB_ARB_CPU;
                  end
               end else if (wd_fire || slv_rsp) begin
                  wd_cnt <= 8'd0;
               end else if (owner_stb) begin
                  wd_cnt <= wd_cnt + 8'd1;
               end
            end
            default: begin
               state  <= ARB_IDLE;
               grant  <= 3'b000;
               owner  <= WB_ARB_CPU;
               wd_cnt <= 8'd0;
            end
         endcase
      end
   end

endmodule
